// File: rtl/toy_fetch_sequencer.sv
// Fetch/execute sequencer for the toy accumulator CPU: owns PC, IR and Z/C flags.
// Optional illegal-opcode trap is enabled by defining TOY_ILLEGAL_TRAP_EN.
module toy_fetch_sequencer #(
    parameter int PC_W     = 8,
    parameter int INSN_W   = 12,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INSN_W-1:0] imem_data,
    input  logic [1:0]        src_pc,
    input  logic              flag_we,
    input  logic              alu_z,
    input  logic              alu_c,
    output logic [3:0]        opcode,
    output logic [PC_W-1:0]   operand,
    output logic              exec_stb,
    output logic              z,
    output logic              c,
    output logic [PC_W-1:0]   pc,
    output logic              busy,
    output logic              trap
);

`ifdef TOY_ILLEGAL_TRAP_EN
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        TRAP
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC
    } state_t;
`endif

    state_t            state;
    state_t            state_next;
    logic [INSN_W-1:0] ir;
    logic [PC_W-1:0]   pc_next;
    logic              do_exec;

    assign opcode    = ir[INSN_W-1 -: 4];
    assign operand   = ir[PC_W-1:0];
    assign imem_addr = pc;

    // An illegal opcode reaching EXEC is swallowed: no strobe, no state update.
`ifdef TOY_ILLEGAL_TRAP_EN
    logic is_illegal;
    assign is_illegal = (opcode == 4'b0111);
    assign do_exec    = (state == EXEC) && !is_illegal;
`else
    assign do_exec    = (state == EXEC);
`endif

    always_comb begin
        pc_next = pc + PC_W'(1);
        case (src_pc)
            2'b01,
            2'b10:   pc_next = operand;
            default: pc_next = pc + PC_W'(1);
        endcase
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        exec_stb   = 1'b0;
        busy       = 1'b0;
        trap       = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                busy     = 1'b1;
                if (imem_ack) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                busy     = 1'b1;
                exec_stb = do_exec;
`ifdef TOY_ILLEGAL_TRAP_EN
                if (is_illegal) begin
                    state_next = TRAP;
                end else begin
                    state_next = run ? FETCH : IDLE;
                end
`else
                state_next = run ? FETCH : IDLE;
`endif
            end
`ifdef TOY_ILLEGAL_TRAP_EN
            TRAP: begin
                trap = 1'b1;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Flags written here are only seen by the next instruction's controller decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= PC_W'(RESET_PC);
            ir    <= '0;
            z     <= 1'b0;
            c     <= 1'b0;
        end else begin
            state <= state_next;
            if ((state == FETCH) && imem_ack) begin
                ir <= imem_data;
            end
            if (do_exec) begin
                pc <= pc_next;
                if (flag_we) begin
                    z <= alu_z;
                    c <= alu_c;
                end
            end
        end
    end

endmodule

// File: doc/toy_fetch_sequencer.md
Name: toy_fetch_sequencer

Overview:
- Multi-cycle fetch/execute sequencer for the toy accumulator CPU; the counterpart of the opcode-decoding controller on the same control interface.
- Owns PC, instruction register (IR) and Z/C flag registers; fetches instructions over a req/ack memory handshake.
- Presents opcode and flags to the controller, consumes its src_pc selection, and issues a one-cycle execute strobe that gates all datapath writes.

Parameters:
- PC_W, 8, program counter / operand address width
- INSN_W, 12, instruction width; opcode = [INSN_W-1 -: 4], operand = [PC_W-1:0]
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = fetch/execute continuously, 0 = stop at next instruction boundary
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  PC_W  fetch address (= pc), stable while imem_req=1
- imem_ack  in  1  memory returns imem_data this cycle
- imem_data  in  INSN_W  instruction word, sampled when imem_req & imem_ack
- src_pc  in  2  from controller: 00 PC+1, 01 jump to operand, 10 branch to operand, 11 PC+1
- flag_we  in  1  datapath: update Z/C this instruction
- alu_z  in  1  ALU zero result
- alu_c  in  1  ALU carry result
- opcode  out  4  IR opcode field to controller
- operand  out  PC_W  IR operand field (SRC/VEC address)
- exec_stb  out  1  one-cycle execute strobe; datapath/dmem writes valid only when high
- z  out  1  registered zero flag
- c  out  1  registered carry flag
- pc  out  PC_W  current program counter
- busy  out  1  1 in FETCH or EXEC
- trap  out  1  illegal-opcode trap (see Optional Feature)

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_PC, IR=0, z=0, c=0, imem_req=0, exec_stb=0, busy=0, trap=0. An in-flight fetch is abandoned; the memory sees req drop.
- States: IDLE, FETCH, EXEC (+TRAP when feature enabled).
- IDLE: outputs quiet; run=1 -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. On a cycle with imem_ack=1: IR<=imem_data, -> EXEC. No ack: stay, address held. Ack of 0 cycles is not possible; minimum FETCH is 1 cycle. imem_ack outside FETCH is ignored.
- EXEC: exactly one cycle, exec_stb=1; controller is combinational on opcode/z/c, so src_pc is valid in this cycle.
  - At the closing edge, pc<=next: 00/11 -> pc+1 (mod 2^PC_W, 0xFF wraps to 0x00); 01/10 -> operand.
  - If flag_we: z<=alu_z, c<=alu_c; otherwise flags are held.
  - Next state FETCH if run=1, else IDLE.
- Latency: an instruction with 0-wait memory takes 2 cycles (FETCH+EXEC); each memory wait cycle adds 1.
- run deasserted mid-FETCH: the fetch completes and the instruction executes; stop occurs after EXEC. Instructions are never split.
- Branch uses the pre-update flags; a flag write in the same EXEC affects only the next instruction.
- opcode/operand are held from IR at all times; meaningful only when exec_stb=1.

Optional Feature:
- Macro TOY_ILLEGAL_TRAP_EN.
- Defined: opcode 4'b0111 in EXEC suppresses exec_stb (stays 0), pc and flags unchanged. The sequencer enters TRAP: trap=1, busy=0, imem_req=0, pc holds the faulting address. Only rst exits TRAP.
- Undefined: no TRAP state; trap tied 0; 0111 executes like any opcode (exec_stb pulses, pc follows src_pc).

Test Plan:
- Reset/start: rst pulse, run=1, 0-wait memory -> pc=0x00, imem_req high the cycle after run; exec_stb pulses every 2nd cycle; pc 0,1,2,3.
- Wait states: ack delayed 3 cycles at pc=0x05 -> imem_addr stays 0x05 for 4 cycles; exactly one exec_stb follows; pc=0x06 after.
- Jump/branch/wrap: src_pc=01 with operand 0x40 -> next imem_addr=0x40. pc=0xFF with src_pc=00 -> next fetch at 0x00. src_pc=11 -> pc+1.
- Flags: flag_we=1, alu_z=1, alu_c=0 in EXEC -> z=1, c=0 next cycle. flag_we=0 with alu_z=0 -> z stays 1.
- Stop/reset mid-op: run=0 during FETCH with ack 2 cycles later -> one exec_stb, then IDLE with imem_req=0. rst asserted during FETCH -> imem_req=0 immediately (async), pc=RESET_PC.
- Trap (TOY_ILLEGAL_TRAP_EN): fetch 0x7AB at pc=0x10 -> no exec_stb, trap=1, pc=0x10, no further imem_req until rst. Without the macro -> exec_stb pulses and pc=0x11.
